// File: rtl/svreal_delay_line_mod.sv
// Multi-stage fixed-point delay line: d is aligned to q's exponent (saturate or wrap),
// then shifted through DEPTH enabled stages with per-stage valid and sticky overflow.
module svreal_delay_line_mod #(
    parameter int  D_WIDTH   = 16,
    parameter int  D_EXP     = -8,
    parameter int  Q_WIDTH   = 16,
    parameter int  Q_EXP     = -8,
    parameter int  DEPTH     = 4,
    parameter int  SATURATE  = 1,
    parameter real INIT_REAL = 0.0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ce,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic signed [D_WIDTH-1:0]     d,
    output logic signed [Q_WIDTH-1:0]     q,
    output logic                          out_valid,
    output logic                          ovf,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

    localparam int OW  = $clog2(DEPTH+1);
    localparam int SH  = D_EXP - Q_EXP;
    localparam int ASH = (SH < 0) ? -SH : SH;
    localparam int AW  = (((D_WIDTH + ASH) > Q_WIDTH) ? (D_WIDTH + ASH) : Q_WIDTH) + 1;

    localparam logic signed [Q_WIDTH-1:0] INIT_CODE =
        Q_WIDTH'($rtoi(INIT_REAL * (2.0 ** (-Q_EXP))));
    localparam logic signed [AW-1:0] QMAX = {{(AW-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] QMIN = {{(AW-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

    if (DEPTH < 1) begin : g_depth_chk
        $fatal(1, "svreal_delay_line_mod: DEPTH must be >= 1");
    end

    logic signed [AW-1:0]  dx, al;
    logic [Q_WIDTH-1:0]    aligned;
    logic                  ovf_ev;

    // Widened so the shifted value never loses bits before the range check.
    assign dx = AW'(d);
    if (SH >= 0) begin : g_lsh
        assign al = dx <<< SH;
    end else begin : g_rsh
        assign al = dx >>> ASH;
    end

    always_comb begin
        aligned = al[Q_WIDTH-1:0];
        ovf_ev  = (al > QMAX) || (al < QMIN);
        if (SATURATE != 0) begin
            if (al > QMAX)      aligned = QMAX[Q_WIDTH-1:0];
            else if (al < QMIN) aligned = QMIN[Q_WIDTH-1:0];
        end
    end

    logic [DEPTH-1:0][Q_WIDTH-1:0] stg;
    logic [DEPTH-1:0]              vld_pipe;
    logic [OW-1:0]                 occ;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) stg[i] <= INIT_CODE;
            vld_pipe <= '0;
            occ      <= '0;
            if (rst) ovf <= 1'b0;
        end else if (ce) begin
            stg[0]      <= aligned;
            vld_pipe[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stg[i]      <= stg[i-1];
                vld_pipe[i] <= vld_pipe[i-1];
            end
            // Track popcount incrementally: one sample in, the last stage's sample out.
            occ <= occ + OW'(in_valid) - OW'(vld_pipe[DEPTH-1]);
            if (in_valid && ovf_ev) ovf <= 1'b1;
        end
    end

    assign q         = $signed(stg[DEPTH-1]);
    assign out_valid = vld_pipe[DEPTH-1];
    assign occupancy = occ;

endmodule

// File: tb/tb_svreal_delay_line_mod.sv
// Directed bench: main DEPTH=4 line (INIT 0.5), saturate/wrap lines fed from exp=-4,
// and a DEPTH=1 line fed from exp=-10.
module tb_svreal_delay_line_mod;

    logic clk = 1'b0;
    logic rst = 1'b1, ce = 1'b0, flush = 1'b0, in_valid = 1'b0;
    logic signed [15:0] d0 = '0, d4 = '0, d10 = '0;

    logic signed [15:0] q0, qs, qw, q1;
    logic ov0, ovs, ovw, ov1;
    logic ovf0, ovfs, ovfw, ovf1;
    logic [2:0] occ0, occs, occw;
    logic [0:0] occ1;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    svreal_delay_line_mod #(.D_WIDTH(16), .D_EXP(-8), .Q_WIDTH(16), .Q_EXP(-8),
        .DEPTH(4), .SATURATE(1), .INIT_REAL(0.5)) u_main (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .d(d0),
        .q(q0), .out_valid(ov0), .ovf(ovf0), .occupancy(occ0));

    svreal_delay_line_mod #(.D_WIDTH(16), .D_EXP(-4), .Q_WIDTH(16), .Q_EXP(-8),
        .DEPTH(4), .SATURATE(1), .INIT_REAL(0.0)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .d(d4),
        .q(qs), .out_valid(ovs), .ovf(ovfs), .occupancy(occs));

    svreal_delay_line_mod #(.D_WIDTH(16), .D_EXP(-4), .Q_WIDTH(16), .Q_EXP(-8),
        .DEPTH(4), .SATURATE(0), .INIT_REAL(0.0)) u_wrap (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .d(d4),
        .q(qw), .out_valid(ovw), .ovf(ovfw), .occupancy(occw));

    svreal_delay_line_mod #(.D_WIDTH(16), .D_EXP(-10), .Q_WIDTH(16), .Q_EXP(-8),
        .DEPTH(1), .SATURATE(1), .INIT_REAL(0.0)) u_d1 (
        .clk(clk), .rst(rst), .ce(ce), .flush(flush), .in_valid(in_valid), .d(d10),
        .q(q1), .out_valid(ov1), .ovf(ovf1), .occupancy(occ1));

    // Drive controls, take one rising edge, and leave outputs settled for sampling.
    task automatic cyc(input logic r, input logic f, input logic c, input logic v);
        rst = r; flush = f; ce = c; in_valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d0 = 16'sd500; d4 = 16'sd3200; d10 = 16'sd7;
        cyc(1, 1, 1, 1);
        cyc(1, 0, 0, 0);
        nvec++;
        if ({ovf0, ov0, occ0, q0} !== {1'b0, 1'b0, 3'd0, 16'h0080}) begin
            nerr++; $display("FAIL reset_main got %h exp %h", {ovf0, ov0, occ0, q0}, {1'b0, 1'b0, 3'd0, 16'h0080});
        end
        nvec++;
        if ({ovfs, ovs, occs, qs, ovfw, ovw, occw, qw} !== '0) begin
            nerr++; $display("FAIL reset_satwrap got %h exp 0", {ovfs, ovs, occs, qs, ovfw, ovw, occw, qw});
        end
        nvec++;
        if ({ovf1, ov1, occ1, q1} !== '0) begin
            nerr++; $display("FAIL reset_d1 got %h exp 0", {ovf1, ov1, occ1, q1});
        end
        d0 = '0; d4 = '0; d10 = '0;
    endtask

    task automatic test_stream();
        int dv[7]   = '{384, 512, -832, 0, 0, 0, 0};
        bit iv[7]   = '{1, 1, 1, 0, 0, 0, 0};
        bit eov[7]  = '{0, 0, 0, 1, 1, 1, 0};
        int eocc[7] = '{1, 2, 3, 3, 2, 1, 0};
        int eq[7]   = '{128, 128, 128, 384, 512, -832, 0};
        logic [20:0] ev;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            d0 = 16'(dv[i]);
            cyc(0, 0, 1, iv[i]);
            ev = {1'b0, eov[i], 3'(eocc[i]), 16'(eq[i])};
            nvec++;
            if ({ovf0, ov0, occ0, q0} !== ev) begin
                nerr++; $display("FAIL stream[%0d] got %h exp %h", i, {ovf0, ov0, occ0, q0}, ev);
            end
        end
    endtask

    task automatic test_stall();
        int dv[9]   = '{384, 512, 999, 999, -832, 0, 0, 0, 0};
        bit cv[9]   = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
        bit iv[9]   = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
        bit eov[9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
        int eocc[9] = '{1, 2, 2, 2, 3, 3, 2, 1, 0};
        int eq[9]   = '{128, 128, 128, 128, 128, 384, 512, -832, 0};
        logic [20:0] ev;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            d0 = 16'(dv[i]);
            cyc(0, 0, cv[i], iv[i]);
            ev = {1'b0, eov[i], 3'(eocc[i]), 16'(eq[i])};
            nvec++;
            if ({ovf0, ov0, occ0, q0} !== ev) begin
                nerr++; $display("FAIL stall[%0d] got %h exp %h", i, {ovf0, ov0, occ0, q0}, ev);
            end
        end
    endtask

    task automatic test_overflow();
        int dv[7]   = '{100, 3200, 3200, -3000, 0, 0, 0};
        bit iv[7]   = '{1, 0, 1, 1, 0, 0, 0};
        bit eovf[7] = '{0, 0, 1, 1, 1, 1, 1};
        bit eov[7]  = '{0, 0, 0, 1, 0, 1, 1};
        int eocc[7] = '{1, 1, 2, 3, 2, 2, 1};
        int eqs[7]  = '{0, 0, 0, 1600, 32767, 32767, -32768};
        int eqw[7]  = '{0, 0, 0, 1600, -14336, -14336, 17536};
        logic [20:0] evs, evw;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            d4 = 16'(dv[i]);
            cyc(0, 0, 1, iv[i]);
            evs = {eovf[i], eov[i], 3'(eocc[i]), 16'(eqs[i])};
            evw = {eovf[i], eov[i], 3'(eocc[i]), 16'(eqw[i])};
            nvec++;
            if ({ovfs, ovs, occs, qs} !== evs) begin
                nerr++; $display("FAIL ovf_sat[%0d] got %h exp %h", i, {ovfs, ovs, occs, qs}, evs);
            end
            nvec++;
            if ({ovfw, ovw, occw, qw} !== evw) begin
                nerr++; $display("FAIL ovf_wrap[%0d] got %h exp %h", i, {ovfw, ovw, occw, qw}, evw);
            end
        end
    endtask

    task automatic test_flush();
        int dv[4] = '{256, 512, 768, 1024};
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            d0 = 16'(dv[i]);
            d4 = (i == 0) ? 16'sd3200 : 16'sd0;
            cyc(0, 0, 1, 1);
        end
        nvec++;
        if ({ov0, occ0, q0, ovfs} !== {1'b1, 3'd4, 16'd256, 1'b1}) begin
            nerr++; $display("FAIL flush_fill got %h exp %h", {ov0, occ0, q0, ovfs}, {1'b1, 3'd4, 16'd256, 1'b1});
        end
        d0 = 16'sd2000; d4 = 16'sd3200;
        cyc(0, 1, 0, 1);
        nvec++;
        if ({ovf0, ov0, occ0, q0} !== {1'b0, 1'b0, 3'd0, 16'h0080}) begin
            nerr++; $display("FAIL flush_main got %h exp %h", {ovf0, ov0, occ0, q0}, {1'b0, 1'b0, 3'd0, 16'h0080});
        end
        nvec++;
        if ({ovfs, ovs, occs, qs} !== {1'b1, 1'b0, 3'd0, 16'h0000}) begin
            nerr++; $display("FAIL flush_sat got %h exp %h", {ovfs, ovs, occs, qs}, {1'b1, 1'b0, 3'd0, 16'h0000});
        end
        d0 = '0; d4 = '0;
        cyc(0, 0, 1, 0);
        nvec++;
        if ({ov0, occ0, q0} !== {1'b0, 3'd0, 16'h0080}) begin
            nerr++; $display("FAIL flush_after got %h exp %h", {ov0, occ0, q0}, {1'b0, 3'd0, 16'h0080});
        end
    endtask

    task automatic test_midreset();
        bit eov[4] = '{0, 0, 0, 1};
        int eq[4]  = '{128, 128, 128, 1280};
        logic [19:0] ev;
        cyc(1, 0, 0, 0);
        d0 = 16'sd256; d4 = 16'sd3200;
        cyc(0, 0, 1, 1);
        d0 = 16'sd512; d4 = '0;
        cyc(0, 0, 1, 1);
        cyc(1, 0, 0, 1);
        nvec++;
        if ({ovf0, ov0, occ0, q0, ovfs} !== {1'b0, 1'b0, 3'd0, 16'h0080, 1'b0}) begin
            nerr++; $display("FAIL midrst got %h exp %h", {ovf0, ov0, occ0, q0, ovfs}, {1'b0, 1'b0, 3'd0, 16'h0080, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            d0 = (i == 0) ? 16'sd1280 : 16'sd0;
            cyc(0, 0, 1, i == 0);
            ev = {eov[i], 3'd1, 16'(eq[i])};
            nvec++;
            if ({ov0, occ0, q0} !== ev) begin
                nerr++; $display("FAIL midrst_restart[%0d] got %h exp %h", i, {ov0, occ0, q0}, ev);
            end
        end
    endtask

    task automatic test_depth1();
        int dv[5]  = '{-3, 7, 5, 32767, -32768};
        bit iv[5]  = '{1, 0, 1, 1, 1};
        int eq[5]  = '{-1, 1, 1, 8191, -8192};
        logic [18:0] ev;
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            d10 = 16'(dv[i]);
            cyc(0, 0, 1, iv[i]);
            ev = {1'b0, iv[i], iv[i], 16'(eq[i])};
            nvec++;
            if ({ovf1, ov1, occ1, q1} !== ev) begin
                nerr++; $display("FAIL depth1[%0d] got %h exp %h", i, {ovf1, ov1, occ1, q1}, ev);
            end
        end
        d10 = '0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_overflow();
        test_flush();
        test_midreset();
        test_depth1();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
